// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath types, counter-width helper and rounding default
package fft_pkg;

   localparam int CPLX_W = 16;
   localparam int ROUND_DEFAULT = 1;

   typedef struct packed {
      logic signed [CPLX_W-1:0] re;
      logic signed [CPLX_W-1:0] im;
   } cplx_t;

   // Ceiling log2, evaluated at elaboration for counter sizing
   function automatic int log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sdf_r2_feedback_stage_if.sv
// rtl/sdf_r2_feedback_stage_if.sv - sample stream into and out of one SDF radix-2 stage
interface sdf_r2_feedback_stage_if #(parameter int WIDTH = 16);

   logic                    in_valid;
   logic                    in_sof;
   logic signed [WIDTH-1:0] in_re;
   logic signed [WIDTH-1:0] in_im;
   logic                    out_valid;
   logic                    out_sof;
   logic signed [WIDTH-1:0] out_re;
   logic signed [WIDTH-1:0] out_im;

   modport master (
      output in_valid, in_sof, in_re, in_im,
      input  out_valid, out_sof, out_re, out_im
   );

   modport slave (
      input  in_valid, in_sof, in_re, in_im,
      output out_valid, out_sof, out_re, out_im
   );

endinterface

// File: rtl/sdf_r2_feedback_stage_delay_line.sv
// rtl/sdf_r2_feedback_stage_delay_line.sv - DEPTH-entry feedback shift register, output is the oldest entry
module sdf_delay_line #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [2*WIDTH-1:0] din,
   output logic [2*WIDTH-1:0] dout
);

   logic [2*WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (en) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
   end

   assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sdf_r2_feedback_stage.sv
// rtl/sdf_r2_feedback_stage.sv - radix-2 SDF stage: phase counter, feedback butterfly, output register; SDF_BYPASS_EN adds bypass
module sdf_r2_feedback_stage
   import fft_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int ROUND = ROUND_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
`ifdef SDF_BYPASS_EN
   input  logic bypass,
`endif
   sdf_r2_feedback_stage_if.slave bus
);

   localparam int CW = log2(2 * DEPTH);

   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_eff;
   logic               phase;
   logic               primed;
   logic               dl_en;
   logic [2*WIDTH-1:0] dl_in;
   logic [2*WIDTH-1:0] dl_out;
   logic [WIDTH-1:0]   dl_re, dl_im, y_re, y_im;

   // (a +/- b + ROUND) >>> 1 at WIDTH+1 bits; bits [WIDTH:1] are the shifted, truncated result
   function automatic logic [WIDTH-1:0] half_bfly(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sub);
      logic [WIDTH:0] s;
      if (sub) s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
      else     s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      s = s + (WIDTH+1)'(ROUND);
      return s[WIDTH:1];
   endfunction

   assign cnt_eff = bus.in_sof ? '0 : cnt;
   assign phase   = cnt_eff[CW-1];
   assign dl_re   = dl_out[2*WIDTH-1:WIDTH];
   assign dl_im   = dl_out[WIDTH-1:0];

`ifdef SDF_BYPASS_EN
   assign dl_en = bus.in_valid & ~bypass;
`else
   assign dl_en = bus.in_valid;
`endif

   always_comb begin
      y_re  = dl_re;
      y_im  = dl_im;
      dl_in = {bus.in_re, bus.in_im};
      if (phase) begin
         y_re  = half_bfly(dl_re, bus.in_re, 1'b0);
         y_im  = half_bfly(dl_im, bus.in_im, 1'b0);
         dl_in = {half_bfly(dl_re, bus.in_re, 1'b1), half_bfly(dl_im, bus.in_im, 1'b1)};
      end
   end

   sdf_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_delay_line (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (dl_en),
      .din  (dl_in),
      .dout (dl_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         primed        <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_sof   <= 1'b0;
         bus.out_re    <= '0;
         bus.out_im    <= '0;
`ifdef SDF_BYPASS_EN
      end else if (bypass) begin
         bus.out_valid <= bus.in_valid;
         bus.out_sof   <= bus.in_valid & bus.in_sof;
         bus.out_re    <= bus.in_re;
         bus.out_im    <= bus.in_im;
`endif
      end else if (bus.in_valid) begin
         cnt           <= cnt_eff + CW'(1);
         primed        <= primed | phase;
         // Phase-0 outputs before the first phase-1 accept carry only reset contents
         bus.out_valid <= primed | phase;
         bus.out_sof   <= (cnt_eff == CW'(DEPTH));
         bus.out_re    <= y_re;
         bus.out_im    <= y_im;
      end else begin
         bus.out_valid <= 1'b0;
         bus.out_sof   <= 1'b0;
      end
   end

endmodule
